// File: rtl/dds_param_scheduler.sv
// Timed DDS parameter source: owns the 48-bit timestamp and a small FIFO of
// timestamped frequency/phase updates, applying each one when its time arrives.
module dds_param_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        ts_clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] cmd_time,
    input  logic [47:0] cmd_freq,
    input  logic [13:0] cmd_phase,
    input  logic        cmd_phase_reset,
    input  logic        err_clear,
    output logic [47:0] timestamp,
    output logic [47:0] timeoffset,
    output logic [47:0] freq,
    output logic [13:0] phase,
    output logic        update,
    output logic        late_flag
);

    localparam int unsigned TW = 48;
    localparam int unsigned PW = 14;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [TW-1:0] freq;
        logic [PW-1:0] phase;
        logic          phase_reset;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [TW-1:0] ts_next;
    logic          push;
    logic          pop;
    logic          is_late;

    // Apply decision is made against the timestamp value that becomes visible
    // at this edge, so on-time updates land in the cycle timestamp == cmd_time.
    always_comb begin
        ts_next    = ts_clear ? '0 : (run ? timestamp + TW'(1) : timestamp);
        head       = mem[rd_ptr];
        push       = cmd_valid & cmd_ready;
        pop        = (count != '0) && (head.t <= ts_next);
        is_late    = pop && (head.t < ts_next);
        count_next = count + CW'(push) - CW'(pop);
    end

    // Command storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{t: cmd_time, freq: cmd_freq, phase: cmd_phase,
                             phase_reset: cmd_phase_reset};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            cmd_ready  <= 1'b1;
            timestamp  <= '0;
            timeoffset <= '0;
            freq       <= '0;
            phase      <= '0;
            update     <= 1'b0;
            late_flag  <= 1'b0;
        end else begin
            timestamp <= ts_next;
            count     <= count_next;
            cmd_ready <= (count_next != CW'(DEPTH));
            update    <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                freq   <= head.freq;
                phase  <= head.phase;
                if (head.phase_reset) begin
                    timeoffset <= ts_next;
                end
            end
            // A new late event outranks a simultaneous clear.
            if (is_late) begin
                late_flag <= 1'b1;
            end else if (err_clear) begin
                late_flag <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dds_param_scheduler.md
# dds_param_scheduler

Timed parameter source for the DAC-controller phase MAC. Owns the 48-bit timestamp counter and a small command FIFO of timestamped DDS updates (frequency, phase, optional phase-coherent restart), and drives the MAC operands (time offset, frequency, phase, timestamp). Each queued update is applied exactly when the timestamp reaches its programmed time. Late commands are applied immediately and flagged.

## Interface
- DEPTH, 4: command FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- run  in  1  timestamp counter increments by 1 per cycle while high
- ts_clear  in  1  synchronous timestamp clear; priority over run
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full; reset value 1
- cmd_time  in  48  timestamp at which the command takes effect
- cmd_freq  in  48  new frequency word
- cmd_phase  in  14  new phase word
- cmd_phase_reset  in  1  1: load time offset so that (timestamp − offset) = 0 at application
- err_clear  in  1  clears late_flag
- timestamp  out  48  current timestamp (MAC D), reset 0
- timeoffset  out  48  MAC A, reset 0
- freq  out  48  MAC B, reset 0
- phase  out  14  MAC C, reset 0
- update  out  1  one-cycle pulse, high in the first cycle new parameters are visible; reset 0
- late_flag  out  1  sticky, a command was applied after its time; reset 0

## Operation
- ts_next = 0 if ts_clear, else timestamp+1 if run, else timestamp. timestamp <= ts_next every edge; 48-bit wrap 2^48−1 → 0, no wrap compensation.
- FIFO: push when cmd_valid & cmd_ready; cmd_ready = !full, registered, no combinational dependence on pop. Entry = {time, freq, phase, phase_reset}.
- Apply condition at an edge: FIFO non-empty and head.time ≤ ts_next (unsigned). At most one command applied per edge; head popped.
- On apply: freq <= head.freq, phase <= head.phase, timeoffset <= ts_next if head.phase_reset else unchanged, update <= 1. Otherwise update <= 0, parameters hold.
- head.time < ts_next at apply → late_flag <= 1. err_clear clears late_flag; simultaneous new late event wins (flag stays 1).
- Multiple late commands drain one per cycle, each producing an update pulse.
- Push and pop in same edge allowed; occupancy unchanged. When full, pop in cycle N makes cmd_ready 1 in cycle N+1.
- Async reset (any time, including mid-drain): FIFO emptied, all outputs to reset values, pending commands discarded.

## Timing
- Pushed command reaches FIFO head one cycle after acceptance; earliest application at the following edge.
- On-time command: new freq/phase/timeoffset and update pulse appear in the same cycle timestamp first equals cmd_time.
- phase_reset command applied on time at T: timeoffset = T in the cycle timestamp = T (MAC sees D−A = 0).
- With run=0 the timestamp is frozen; a command with time == timestamp applies at the next edge, not late.
- ts_clear cycle: timestamp shows 0 next cycle; head commands with time 0 apply on that edge, on time.

## Test plan
- Reset: hold resetn=0 mid-stream with 3 queued entries → after release all outputs 0, cmd_ready=1, queued commands never applied.
- On-time: run=1 from 0; push {time=100, freq=0x1000, phase=0x155, phase_reset=1} → update=1 exactly in cycle timestamp=100, freq=0x1000, phase=0x155, timeoffset=100; no late_flag.
- Back-to-back: push times 50, 51, 52 → three consecutive update pulses aligned to timestamp 50, 51, 52; timeoffset unchanged when phase_reset=0.
- Late: at timestamp 200 push time=150 and time=160 → two update pulses on consecutive cycles starting 2 cycles after first acceptance, late_flag=1; err_clear → 0.
- Full FIFO: push DEPTH far-future commands → cmd_ready=0, extra cmd_valid ignored; ts reaches first time → cmd_ready=1 next cycle, order preserved.
- ts_clear/run=0: freeze at 500 with time=500 queued → applies next edge, late_flag=0; ts_clear with head time=0 → applied as timestamp shows 0.
